// File: rtl/fir_da_sequencer.sv
// fir_da_sequencer: bit-serial control sequencer for the FIR distributed-arithmetic datapath.
// Pops one sample from the FIFO, loads the tap shift registers, steps the DA accumulator
// through DATA_W bit-slices (LSB first, sign slice last), then holds the finished sum
// on a valid/ready handshake.
// Optional feature: define FIR_SEQ_STARVE_EN to add the starve_cnt port, a saturating
// count of idle cycles spent waiting on an empty FIFO after the first delivered sample.
module fir_da_sequencer #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk3,
  input  logic              reset,
  input  logic              fifo_empty,
  output logic              fifo_read,
  output logic              sreg_load,
  output logic              sreg_shift,
  output logic              da_clear,
  output logic              da_acc_en,
  output logic              da_msb,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt
`ifdef FIR_SEQ_STARVE_EN
  ,
  output logic [CNT_W-1:0]  starve_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic             last_slice;
  logic             accept;

  assign last_slice = (state_q == SHIFT) && (bit_idx_q == LAST_IDX);
  assign accept     = (state_q == HOLD) && sum_ready;

  // State register: reset discards any sample in flight.
  always_ff @(posedge clk3) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a FIFO read always leads into LOAD; the sign slice ends SHIFT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fifo_read) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (last_slice) state_d = HOLD;
      HOLD:  if (sum_ready) state_d = fifo_read ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the read strobe is gated by reset so nothing is popped while resetting.
  always_comb begin
    fifo_read  = 1'b0;
    sreg_load  = 1'b0;
    sreg_shift = 1'b0;
    da_clear   = 1'b0;
    da_acc_en  = 1'b0;
    da_msb     = 1'b0;
    sum_valid  = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE:  fifo_read = !reset && !fifo_empty;
      LOAD: begin
        sreg_load = 1'b1;
        da_clear  = 1'b1;
      end
      SHIFT: begin
        sreg_shift = 1'b1;
        da_acc_en  = 1'b1;
        da_msb     = (bit_idx_q == LAST_IDX);
      end
      HOLD: begin
        sum_valid = 1'b1;
        fifo_read = !reset && sum_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // Slice index advances only while shifting; it is parked at zero everywhere else.
  always_comb begin
    bit_idx_d    = '0;
    sample_cnt_d = sample_cnt_q;
    if (state_q == SHIFT && !last_slice) bit_idx_d = bit_idx_q + 1'b1;
    if (accept) sample_cnt_d = sample_cnt_q + 1'b1;
  end

  // Slice index and delivered-sample counter (counter wraps naturally).
  always_ff @(posedge clk3) begin
    if (reset) begin
      bit_idx_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      bit_idx_q    <= bit_idx_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign bit_idx    = bit_idx_q;
  assign sample_cnt = sample_cnt_q;

`ifdef FIR_SEQ_STARVE_EN
  logic             served_q, served_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Starvation only counts once the pipeline has produced at least one result.
  always_comb begin
    served_d     = served_q | accept;
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE && fifo_empty && served_q && starve_cnt_q != {CNT_W{1'b1}})
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Starve counter state: saturating, cleared only by reset.
  always_ff @(posedge clk3) begin
    if (reset) begin
      served_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      served_q     <= served_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt = starve_cnt_q;
`endif

endmodule
